// File: rtl/log_reader_pkg.sv
// Shared definitions for the log reader output side: FSM state encoding,
// location of the length field in an entry-header line, and the helpers
// that turn an entry byte length into line count and last-line padding.
package log_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TX_MSG_HDR = 3'd1,
    ST_ENTRY_HDR  = 3'd2,
    ST_ENTRY_DATA = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // Entry-header line: the entry data length sits at the bottom of the line;
  // its width is the byte-length width (SIZE_W) of the instantiating block.
  localparam int unsigned LEN_LSB = 0;

  // Reference line geometry for the default 512-bit build.
  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_BYTES  = DEF_DATA_W / 8;

  // Bytes per line for a given line width in bits.
  function automatic int unsigned bytes_per_line(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Number of lines needed for len bytes: ceil(len / 2**byte_log).
  function automatic logic [31:0] lines_calc(input logic [31:0] len,
                                             input int unsigned byte_log);
    logic [32:0] sum;
    sum = {1'b0, len} + ((33'd1 << byte_log) - 33'd1);
    return 32'(sum >> byte_log);
  endfunction

  // Unused trailing bytes in the last line: (bytes - len mod bytes) mod bytes.
  // bytes is a power of two, so both modulos reduce to a mask.
  function automatic logic [31:0] pad_calc(input logic [31:0] len,
                                           input logic [31:0] bytes);
    return (bytes - (len & (bytes - 32'd1))) & (bytes - 32'd1);
  endfunction

endpackage

// File: rtl/log_reader_out_datapath.sv
// Datapath of the log reader output controller: descriptor latches,
// remaining-entry and remaining-line counters and the last-line pad register.
// All updates are strobed by the FSM in log_reader_out_ctrl.
module log_reader_out_datapath
  import log_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned SIZE_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PAD_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_take,
  input  logic              hdr_take,
  input  logic              data_take,
  input  logic [31:0]       desc_view,
  input  logic [CNT_W-1:0]  desc_num_entries,
  input  logic [SIZE_W-1:0] desc_total_bytes,
  input  logic [SIZE_W-1:0] hdr_len,
  output logic [31:0]       view,
  output logic [CNT_W-1:0]  num_entries,
  output logic [SIZE_W-1:0] total_bytes,
  output logic [PAD_W-1:0]  pad,
  output logic              len_zero,
  output logic              len_over_total,
  output logic              entries_none,
  output logic              entries_left_one,
  output logic              entries_left_zero,
  output logic              lines_left_one
);

  localparam int unsigned BYTES    = bytes_per_line(DATA_W);
  localparam int unsigned BYTE_LOG = $clog2(BYTES);

  logic [CNT_W-1:0]  entries_left;
  logic [SIZE_W-1:0] lines_left;
  logic [31:0]       len_ext;
  logic [31:0]       lines_full;
  logic [31:0]       pad_full;
  logic [SIZE_W-1:0] lines_val;
  logic [PAD_W-1:0]  pad_val;
  logic [63-SIZE_W-PAD_W:0] unused_hi;

  assign len_ext    = 32'(hdr_len);
  assign lines_full = lines_calc(len_ext, BYTE_LOG);
  assign pad_full   = pad_calc(len_ext, BYTES);
  assign lines_val  = lines_full[SIZE_W-1:0];
  assign pad_val    = pad_full[PAD_W-1:0];
  // Line count and pad never exceed their narrow fields; high bits are dropped.
  assign unused_hi  = {lines_full[31:SIZE_W], pad_full[31:PAD_W]};

  assign len_zero          = (hdr_len == '0);
  assign len_over_total    = (hdr_len > total_bytes);
  assign entries_none      = (num_entries == '0);
  assign entries_left_one  = (entries_left == CNT_W'(1));
  assign entries_left_zero = (entries_left == '0);
  assign lines_left_one    = (lines_left == SIZE_W'(1));

  // Latch the descriptor, then count entries and lines down as beats leave.
  always_ff @(posedge clk) begin
    if (rst) begin
      view         <= '0;
      num_entries  <= '0;
      total_bytes  <= '0;
      entries_left <= '0;
      lines_left   <= '0;
      pad          <= '0;
    end else begin
      if (desc_take) begin
        view         <= desc_view;
        num_entries  <= desc_num_entries;
        total_bytes  <= desc_total_bytes;
        entries_left <= desc_num_entries;
      end
      if (hdr_take) begin
        entries_left <= entries_left - CNT_W'(1);
        lines_left   <= lines_val;
        pad          <= pad_val;
      end else if (data_take) begin
        lines_left   <= lines_left - SIZE_W'(1);
      end
    end
  end

endmodule

// File: rtl/log_reader_out_ctrl.sv
// Log reader output controller. Takes one response descriptor, sends the
// message header, then forwards entry-header and entry-data lines from the
// write-header FIFO onto the transmit data channel with last/padbytes framing,
// and pulses output_done once the whole response has been accepted.
//
// Optional build macro: LOG_READER_OUT_CHECK_EN enables the sticky proto_err
// framing check (line kind vs. state, entry length vs. response total).
module log_reader_out_ctrl
  import log_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned SIZE_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PAD_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resp_desc_val,
  output logic              resp_desc_rdy,
  input  logic [31:0]       resp_desc_view,
  input  logic [CNT_W-1:0]  resp_desc_num_entries,
  input  logic [SIZE_W-1:0] resp_desc_total_bytes,
  input  logic              fifo_rd_val,
  input  logic              fifo_rd_entry_hdr,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_rdy,
  output logic              out_hdr_val,
  input  logic              out_hdr_rdy,
  output logic [31:0]       out_hdr_view,
  output logic [CNT_W-1:0]  out_hdr_num_entries,
  output logic [SIZE_W-1:0] out_hdr_total_bytes,
  output logic              out_data_val,
  input  logic              out_data_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_last,
  output logic [PAD_W-1:0]  out_data_padbytes,
  output logic              output_done,
  output logic              proto_err
);

  // state         | meaning
  // ST_IDLE       | waiting for a response descriptor
  // ST_TX_MSG_HDR | message header offered on the header channel
  // ST_ENTRY_HDR  | forwarding the next entry-header line
  // ST_ENTRY_DATA | forwarding data lines of the current entry
  // ST_DONE       | one-cycle output_done pulse, then back to idle
  state_t state;

  logic desc_rdy_q;
  logic hdr_val_q;
  logic done_q;

  logic in_hdr;
  logic in_data;
  logic in_entry;
  logic beat_take;
  logic desc_take;
  logic hdr_take;
  logic data_take;

  logic [SIZE_W-1:0] hdr_len;
  logic [PAD_W-1:0]  pad;
  logic len_zero;
  logic len_over_total;
  logic entries_none;
  logic entries_left_one;
  logic entries_left_zero;
  logic lines_left_one;

  assign in_hdr    = (state == ST_ENTRY_HDR);
  assign in_data   = (state == ST_ENTRY_DATA);
  assign in_entry  = in_hdr | in_data;
  assign beat_take = out_data_val & out_data_rdy;
  assign desc_take = (state == ST_IDLE) & desc_rdy_q & resp_desc_val;
  assign hdr_take  = in_hdr & beat_take;
  assign data_take = in_data & beat_take;
  assign hdr_len   = fifo_rd_data[LEN_LSB +: SIZE_W];

  // Lines pass straight through; valid is gated only by state, never by ready.
  assign out_data_val      = in_entry & fifo_rd_val;
  assign fifo_rd_rdy       = in_entry & out_data_rdy;
  assign out_data          = fifo_rd_data;
  assign out_data_padbytes = (in_data && lines_left_one) ? pad : '0;
  assign out_data_last     = (in_hdr  && len_zero && entries_left_one) ||
                             (in_data && lines_left_one && entries_left_zero);

  assign resp_desc_rdy = desc_rdy_q;
  assign out_hdr_val   = hdr_val_q;
  assign output_done   = done_q;

  log_reader_out_datapath #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W),
    .CNT_W  (CNT_W),
    .PAD_W  (PAD_W)
  ) u_datapath (
    .clk               (clk),
    .rst               (rst),
    .desc_take         (desc_take),
    .hdr_take          (hdr_take),
    .data_take         (data_take),
    .desc_view         (resp_desc_view),
    .desc_num_entries  (resp_desc_num_entries),
    .desc_total_bytes  (resp_desc_total_bytes),
    .hdr_len           (hdr_len),
    .view              (out_hdr_view),
    .num_entries       (out_hdr_num_entries),
    .total_bytes       (out_hdr_total_bytes),
    .pad               (pad),
    .len_zero          (len_zero),
    .len_over_total    (len_over_total),
    .entries_none      (entries_none),
    .entries_left_one  (entries_left_one),
    .entries_left_zero (entries_left_zero),
    .lines_left_one    (lines_left_one)
  );

  // Response sequencing; descriptor ready, header valid and done are registered.
  // Ready comes up one cycle after entering idle so it is low right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      desc_rdy_q <= 1'b0;
      hdr_val_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (desc_take) begin
            desc_rdy_q <= 1'b0;
            hdr_val_q  <= 1'b1;
            state      <= ST_TX_MSG_HDR;
          end else begin
            desc_rdy_q <= 1'b1;
          end
        end
        ST_TX_MSG_HDR: begin
          if (out_hdr_rdy) begin
            hdr_val_q <= 1'b0;
            if (entries_none) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_ENTRY_HDR;
            end
          end
        end
        ST_ENTRY_HDR: begin
          if (hdr_take) begin
            if (!len_zero) begin
              state <= ST_ENTRY_DATA;
            end else if (entries_left_one) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_ENTRY_DATA: begin
          if (data_take && lines_left_one) begin
            if (entries_left_zero) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_ENTRY_HDR;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LOG_READER_OUT_CHECK_EN
  logic proto_q;

  // Sticky framing error: wrong line kind for the state, or an entry longer
  // than the whole response. Lines are still forwarded unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_q <= 1'b0;
    end else if (hdr_take && (!fifo_rd_entry_hdr || len_over_total)) begin
      proto_q <= 1'b1;
    end else if (data_take && fifo_rd_entry_hdr) begin
      proto_q <= 1'b1;
    end
  end

  assign proto_err = proto_q;
`else
  logic unused_chk;

  assign unused_chk = fifo_rd_entry_hdr ^ len_over_total;
  assign proto_err  = 1'b0;
`endif

endmodule

// File: tb/tb_log_reader_out_ctrl.sv
// Directed bench for log_reader_out_ctrl (DATA_W=512, 64 bytes per line).
module tb_log_reader_out_ctrl;

  localparam int DATA_W = 512;
  localparam int SIZE_W = 16;
  localparam int CNT_W  = 8;
  localparam int PAD_W  = 6;

`ifdef LOG_READER_OUT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              resp_desc_val = 1'b0;
  logic              resp_desc_rdy;
  logic [31:0]       resp_desc_view = '0;
  logic [CNT_W-1:0]  resp_desc_num_entries = '0;
  logic [SIZE_W-1:0] resp_desc_total_bytes = '0;
  logic              fifo_rd_val = 1'b0;
  logic              fifo_rd_entry_hdr = 1'b0;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              fifo_rd_rdy;
  logic              out_hdr_val;
  logic              out_hdr_rdy = 1'b0;
  logic [31:0]       out_hdr_view;
  logic [CNT_W-1:0]  out_hdr_num_entries;
  logic [SIZE_W-1:0] out_hdr_total_bytes;
  logic              out_data_val;
  logic              out_data_rdy = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_data_last;
  logic [PAD_W-1:0]  out_data_padbytes;
  logic              output_done;
  logic              proto_err;

  always #5 clk = ~clk;

  log_reader_out_ctrl #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W),
    .CNT_W  (CNT_W),
    .PAD_W  (PAD_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .resp_desc_val         (resp_desc_val),
    .resp_desc_rdy         (resp_desc_rdy),
    .resp_desc_view        (resp_desc_view),
    .resp_desc_num_entries (resp_desc_num_entries),
    .resp_desc_total_bytes (resp_desc_total_bytes),
    .fifo_rd_val           (fifo_rd_val),
    .fifo_rd_entry_hdr     (fifo_rd_entry_hdr),
    .fifo_rd_data          (fifo_rd_data),
    .fifo_rd_rdy           (fifo_rd_rdy),
    .out_hdr_val           (out_hdr_val),
    .out_hdr_rdy           (out_hdr_rdy),
    .out_hdr_view          (out_hdr_view),
    .out_hdr_num_entries   (out_hdr_num_entries),
    .out_hdr_total_bytes   (out_hdr_total_bytes),
    .out_data_val          (out_data_val),
    .out_data_rdy          (out_data_rdy),
    .out_data              (out_data),
    .out_data_last         (out_data_last),
    .out_data_padbytes     (out_data_padbytes),
    .output_done           (output_done),
    .proto_err             (proto_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] fq_data[$];
  logic              fq_hdr[$];
  logic [31:0]       exp_tag[$];
  logic [31:0]       bt_tag[$];
  logic              bt_last[$];
  logic [PAD_W-1:0]  bt_pad[$];
  logic [PAD_W-1:0]  exp_pad[8];
  logic              exp_last[8];

  int          hdr_cnt, done_cnt, hdr_cyc, done_cyc, stall_bad;
  logic [31:0] hdr_view;
  logic [CNT_W-1:0]  hdr_n;
  logic [SIZE_W-1:0] hdr_tot;
  bit          desc_pend = 1'b0;
  bit          gaps = 1'b0;
  bit          toggle = 1'b0;
  logic [31:0] next_tag = 32'h100;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic hdr, input logic [15:0] len);
    logic [DATA_W-1:0] line;
    line = '0;
    line[511:480] = next_tag;
    line[15:0] = len;
    fq_data.push_back(line);
    fq_hdr.push_back(hdr);
    exp_tag.push_back(next_tag);
    next_tag++;
  endtask

  task automatic push_entry(input logic [15:0] len);
    push_line(1'b1, len);
    for (int i = 0; i < (int'(len) + 63) / 64; i++) push_line(1'b0, 16'hBEEF);
  endtask

  task automatic clear_rec();
    bt_tag.delete();
    bt_last.delete();
    bt_pad.delete();
    hdr_cnt = 0; done_cnt = 0; hdr_cyc = 0; done_cyc = 0; stall_bad = 0;
  endtask

  task automatic set_exp(input int i, input logic [PAD_W-1:0] p, input logic l);
    exp_pad[i]  = p;
    exp_last[i] = l;
  endtask

  // One clock: drive inputs after the edge, observe at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    resp_desc_val = desc_pend;
    fifo_rd_val = (fq_data.size() > 0) && !(gaps && (cyc % 3 == 1));
    if (fq_data.size() > 0) begin
      fifo_rd_data = fq_data[0];
      fifo_rd_entry_hdr = fq_hdr[0];
    end else begin
      fifo_rd_data = '0;
      fifo_rd_entry_hdr = 1'b0;
    end
    out_data_rdy = toggle ? (cyc % 2 == 0) : 1'b1;
    out_hdr_rdy = 1'b1;
    @(negedge clk);
    if (resp_desc_val && resp_desc_rdy) desc_pend = 1'b0;
    if (out_hdr_val && out_hdr_rdy) begin
      hdr_cnt++;
      hdr_cyc = cyc;
      hdr_view = out_hdr_view;
      hdr_n = out_hdr_num_entries;
      hdr_tot = out_hdr_total_bytes;
    end
    if (out_data_val && !fifo_rd_val) stall_bad++;
    if (out_data_val && out_data_rdy) begin
      bt_tag.push_back(out_data[511:480]);
      bt_last.push_back(out_data_last);
      bt_pad.push_back(out_data_padbytes);
    end
    if (fifo_rd_val && fifo_rd_rdy) begin
      void'(fq_data.pop_front());
      void'(fq_hdr.pop_front());
    end
    if (output_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic run_resp(input logic [31:0] v, input logic [CNT_W-1:0] n, input logic [SIZE_W-1:0] tb);
    int k;
    clear_rec();
    resp_desc_view = v;
    resp_desc_num_entries = n;
    resp_desc_total_bytes = tb;
    desc_pend = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      cycle();
      k++;
    end
    repeat (3) cycle();
  endtask

  task automatic check_beats(input string nm, input int n);
    check_val({nm, "_count"}, bt_tag.size(), n);
    for (int i = 0; i < n && i < bt_tag.size(); i++) begin
      check_val($sformatf("%s_tag%0d", nm, i), bt_tag[i], exp_tag[i]);
      check_val($sformatf("%s_pad%0d", nm, i), bt_pad[i], exp_pad[i]);
      check_val($sformatf("%s_last%0d", nm, i), bt_last[i], exp_last[i]);
    end
    check_val({nm, "_done"}, done_cnt, 1);
    exp_tag.delete();
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_desc_rdy", resp_desc_rdy, 0);
    check_val("rst_hdr_val", out_hdr_val, 0);
    check_val("rst_data_val", out_data_val, 0);
    check_val("rst_done", output_done, 0);
    check_val("rst_proto", proto_err, 0);

    // zero entries: header only, done one cycle after the header handshake
    run_resp(32'd7, 8'd0, 16'd0);
    check_val("t1_hdr_cnt", hdr_cnt, 1);
    check_val("t1_view", hdr_view, 7);
    check_val("t1_n", hdr_n, 0);
    check_val("t1_beats", bt_tag.size(), 0);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_done_lat", done_cyc - hdr_cyc, 1);

    // one entry, L=100: two data lines, pad 128-100=28
    push_entry(16'd100);
    run_resp(32'd2, 8'd1, 16'd100);
    check_val("t2_total", hdr_tot, 100);
    set_exp(0, 0, 0); set_exp(1, 0, 0); set_exp(2, 28, 1);
    check_beats("t2", 3);
    check_val("t2_proto", proto_err, 0);

    // two entries L=64 then L=0: last flagged on the second header
    push_entry(16'd64);
    push_entry(16'd0);
    run_resp(32'd3, 8'd2, 16'd64);
    set_exp(0, 0, 0); set_exp(1, 0, 0); set_exp(2, 0, 1);
    check_beats("t3", 3);

    // L=130 with ready toggling and FIFO gaps: 3 lines, pad 192-130=62
    gaps = 1'b1;
    toggle = 1'b1;
    push_entry(16'd130);
    run_resp(32'd4, 8'd1, 16'd130);
    gaps = 1'b0;
    toggle = 1'b0;
    set_exp(0, 0, 0); set_exp(1, 0, 0); set_exp(2, 0, 0); set_exp(3, 62, 1);
    check_beats("t4", 4);
    check_val("t4_stall", stall_bad, 0);

    // reset while forwarding data lines
    push_entry(16'd200);
    clear_rec();
    resp_desc_view = 32'd5;
    resp_desc_num_entries = 8'd1;
    resp_desc_total_bytes = 16'd200;
    desc_pend = 1'b1;
    k = 0;
    while (bt_tag.size() < 2 && k < 100) begin
      cycle();
      k++;
    end
    check_val("t5_reach_data", bt_tag.size(), 2);
    @(posedge clk);
    #1 rst = 1'b1;
    desc_pend = 1'b0;
    resp_desc_val = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    fifo_rd_val = 1'b1;
    out_data_rdy = 1'b1;
    @(negedge clk);
    check_val("t5_data_val", out_data_val, 0);
    check_val("t5_fifo_rdy", fifo_rd_rdy, 0);
    check_val("t5_hdr_val", out_hdr_val, 0);
    check_val("t5_desc_rdy", resp_desc_rdy, 0);
    check_val("t5_done", output_done, 0);
    check_val("t5_last", out_data_last, 0);
    fq_data.delete();
    fq_hdr.delete();
    exp_tag.delete();
    // single full line entry after reset: pad 0, last on the only data line
    push_entry(16'd64);
    run_resp(32'd9, 8'd1, 16'd64);
    check_val("t5_view", hdr_view, 9);
    set_exp(0, 0, 0); set_exp(1, 0, 1);
    check_beats("t5b", 2);

    // data line presented where an entry header is expected
    push_line(1'b0, 16'd10);
    push_line(1'b0, 16'hBEEF);
    run_resp(32'd6, 8'd1, 16'd10);
    set_exp(0, 0, 0); set_exp(1, 54, 1);
    check_beats("t6", 2);
    check_val("t6_proto", proto_err, CHK_EN);
    push_entry(16'd64);
    run_resp(32'd8, 8'd1, 16'd64);
    check_val("t6_proto_sticky", proto_err, CHK_EN);
    exp_tag.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("t6_proto_rst", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
